// File: rtl/hall_pkg.sv
// Shared hall-sensor codes, phase encodings and commutation helpers
// for the BLDC hall commutator.
package hall_pkg;

    localparam logic [2:0] STATE1        = 3'b101;
    localparam logic [2:0] STATE2        = 3'b100;
    localparam logic [2:0] STATE3        = 3'b110;
    localparam logic [2:0] STATE4        = 3'b010;
    localparam logic [2:0] STATE5        = 3'b011;
    localparam logic [2:0] STATE6        = 3'b001;
    localparam logic [2:0] STATE_FAULT   = 3'b111;
    localparam logic [2:0] STATE_NO_CONN = 3'b000;

    localparam logic [2:0] A       = 3'b100;
    localparam logic [2:0] B       = 3'b010;
    localparam logic [2:0] C       = 3'b001;
    localparam logic [2:0] ALL_ON  = 3'b111;
    localparam logic [2:0] ALL_OFF = 3'b000;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

    typedef struct packed {
        logic [2:0] u;
        logic [2:0] z;
    } drive_t;

    function automatic logic [2:0] code_idx(input logic [2:0] code);
        case (code)
            STATE1:  return 3'd1;
            STATE2:  return 3'd2;
            STATE3:  return 3'd3;
            STATE4:  return 3'd4;
            STATE5:  return 3'd5;
            STATE6:  return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    // CW swaps the driven-high phase with the CCW low phase; z is shared.
    function automatic drive_t commutate(input logic [2:0] idx, input logic dir);
        drive_t d;
        logic [2:0] low;
        case (idx)
            3'd1:    begin d.u = A; d.z = C; end
            3'd2:    begin d.u = A; d.z = B; end
            3'd3:    begin d.u = B; d.z = A; end
            3'd4:    begin d.u = B; d.z = C; end
            3'd5:    begin d.u = C; d.z = B; end
            3'd6:    begin d.u = C; d.z = A; end
            default: begin d.u = ALL_OFF; d.z = ALL_ON; end
        endcase
        low = ~(d.u | d.z);
        if (dir && idx != 3'd0)
            d.u = low;
        return d;
    endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser followed by a stability counter; a new code is
// accepted only after it has held for FILTER_CYCLES synchronised cycles.
module hall_glitch_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] hall,
    output logic [2:0] hall_filt
);
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1) + 1;

    logic [2:0]       sync1, sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            cnt       <= '0;
            hall_filt <= '0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
            // sync1 != sync2 means sync2 changes on this edge: restart the count
            if (sync1 != sync2)
                cnt <= '0;
            else if (sync2 == hall_filt)
                cnt <= '0;
            else if (cnt == CNT_W'(FILTER_CYCLES)) begin
                hall_filt <= sync2;
                cnt       <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hall_commutator.sv
// Registered hall-to-phase commutator with step tracking, period
// measurement and a sticky fault that floats all phases.
module hall_commutator
    import hall_pkg::*;
#(
    parameter int FILTER_CYCLES = 8,
    parameter int POS_W         = 16,
    parameter int PERIOD_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              hall,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    fault_clr,
    output logic [2:0]              u,
    output logic [2:0]              z,
    output logic [2:0]              hall_filt,
    output logic signed [POS_W-1:0] position,
    output logic [PERIOD_W-1:0]     period,
    output logic                    period_valid,
    output logic                    step_err,
    output logic                    fault
);
    state_t              state, state_next;
    logic [2:0]          filt_q;
    logic [PERIOD_W-1:0] period_cnt;
    logic [2:0]          idx_new, idx_old;
    logic [3:0]          delta;
    logic                changed, pos_inc, pos_dec, err, restart;
    drive_t              drv;

    hall_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
        .clk       (clk),
        .rst       (rst),
        .hall      (hall),
        .hall_filt (hall_filt)
    );

    assign idx_new = code_idx(hall_filt);
    assign idx_old = code_idx(filt_q);
    assign changed = (hall_filt != filt_q);
    assign delta   = (idx_new >= idx_old) ? {1'b0, idx_new} - {1'b0, idx_old}
                                          : {1'b0, idx_new} + 4'd6 - {1'b0, idx_old};

    always_comb begin
        state_next = state;
        pos_inc    = 1'b0;
        pos_dec    = 1'b0;
        err        = 1'b0;
        case (state)
            S_INIT:
                if (idx_new != 3'd0)
                    state_next = S_RUN;
            S_RUN:
                if (changed) begin
                    if (idx_new == 3'd0)
                        state_next = S_FAULT;
                    else if (delta == 4'd1)
                        pos_inc = 1'b1;
                    else if (delta == 4'd5)
                        pos_dec = 1'b1;
                    else begin
                        err        = 1'b1;
                        state_next = S_FAULT;
                    end
                end
            // a code change in the clearing cycle counts as a fresh fault event
            S_FAULT:
                if (fault_clr && idx_new != 3'd0 && !changed)
                    state_next = S_INIT;
            default:
                state_next = S_INIT;
        endcase
    end

    assign restart = (state == S_INIT) && (state_next == S_RUN);

    always_comb begin
        drv = commutate(idx_new, dir);
        if (state_next != S_RUN || !en) begin
            drv.u = ALL_OFF;
            drv.z = ALL_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_INIT;
            filt_q       <= '0;
            period_cnt   <= '0;
            period       <= '1;
            period_valid <= 1'b0;
            position     <= '0;
            step_err     <= 1'b0;
            fault        <= 1'b0;
            u            <= ALL_OFF;
            z            <= ALL_ON;
        end else begin
            state        <= state_next;
            filt_q       <= hall_filt;
            period_valid <= pos_inc | pos_dec;
            step_err     <= err;
            fault        <= (state_next == S_FAULT);
            u            <= drv.u;
            z            <= drv.z;

            if (restart)
                period_cnt <= '0;
            else if (pos_inc | pos_dec)
                period_cnt <= PERIOD_W'(1);
            else if (period_cnt != '1)
                period_cnt <= period_cnt + 1'b1;

            if (pos_inc | pos_dec)
                period <= period_cnt;

            if (pos_inc)
                position <= position + 1'b1;
            else if (pos_dec)
                position <= position - 1'b1;
        end
    end

endmodule

// File: tb/tb_hall_commutator.sv
// Directed bench for hall_commutator: expected drive/position/fault records
// are queued as each hall step is applied and checked after it settles.
module tb_hall_commutator;
    localparam int F   = 8;
    localparam int PW  = 4;
    localparam int PRW = 10;

    logic            clk = 1'b0;
    logic            rst, en, dir, fault_clr;
    logic [2:0]      hall, u, z, hall_filt;
    logic signed [PW-1:0] position;
    logic [PRW-1:0]  period;
    logic            period_valid, step_err, fault;

    always #5 clk = ~clk;

    hall_commutator #(.FILTER_CYCLES(F), .POS_W(PW), .PERIOD_W(PRW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hall         (hall),
        .en           (en),
        .dir          (dir),
        .fault_clr    (fault_clr),
        .u            (u),
        .z            (z),
        .hall_filt    (hall_filt),
        .position     (position),
        .period       (period),
        .period_valid (period_valid),
        .step_err     (step_err),
        .fault        (fault)
    );

    typedef struct {
        string      tag;
        logic [2:0] u;
        logic [2:0] z;
        int         pos;
        logic       flt;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0, n_fail = 0;
    int pv_cnt = 0, se_cnt = 0, last_period = 0;

    always @(negedge clk) begin
        if (period_valid) begin
            pv_cnt++;
            last_period = int'(period);
        end
        if (step_err) se_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference commutation table, written independently of the RTL package.
    task automatic push_exp(input string tag, input logic [2:0] code, input logic d,
                            input int pos, input logic flt, input logic drive);
        exp_t e;
        logic [2:0] hi, hz, lo;
        case (code)
            3'b101:  begin hi = 3'b100; hz = 3'b001; lo = 3'b010; end
            3'b100:  begin hi = 3'b100; hz = 3'b010; lo = 3'b001; end
            3'b110:  begin hi = 3'b010; hz = 3'b100; lo = 3'b001; end
            3'b010:  begin hi = 3'b010; hz = 3'b001; lo = 3'b100; end
            3'b011:  begin hi = 3'b001; hz = 3'b010; lo = 3'b100; end
            3'b001:  begin hi = 3'b001; hz = 3'b100; lo = 3'b010; end
            default: begin hi = 3'b000; hz = 3'b111; lo = 3'b000; end
        endcase
        e.tag = tag;
        e.pos = pos;
        e.flt = flt;
        if (drive && !flt) begin
            e.u = d ? lo : hi;
            e.z = hz;
        end else begin
            e.u = 3'b000;
            e.z = 3'b111;
        end
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".u"},     int'(u), int'(e.u));
        chk({e.tag, ".z"},     int'(z), int'(e.z));
        chk({e.tag, ".pos"},   int'(position), e.pos);
        chk({e.tag, ".fault"}, int'(fault), int'(e.flt));
    endtask

    task automatic step(input string tag, input logic [2:0] code, input int n, input int pos);
        hall = code;
        push_exp(tag, code, dir, pos, 1'b0, en);
        cyc(n);
        check_sb();
    endtask

    initial begin
        logic [2:0] down_seq [8];
        int se0, pv0;
        down_seq = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

        rst = 1'b1; hall = 3'b000; en = 1'b1; dir = 1'b0; fault_clr = 1'b0;
        cyc(3);
        chk("rst.u", int'(u), 0);
        chk("rst.z", int'(z), 7);
        chk("rst.hall_filt", int'(hall_filt), 0);
        chk("rst.position", int'(position), 0);
        chk("rst.period", int'(period), (1 << PRW) - 1);
        chk("rst.period_valid", int'(period_valid), 0);
        chk("rst.step_err", int'(step_err), 0);
        chk("rst.fault", int'(fault), 0);
        rst = 1'b0;
        cyc(1);

        // Latency: hall_filt at E10, outputs at E11 for F=8
        hall = 3'b101;
        push_exp("start", 3'b101, 1'b0, 0, 1'b0, 1'b1);
        cyc(11);
        chk("e10.hall_filt", int'(hall_filt), 5);
        chk("e10.u", int'(u), 0);
        cyc(1);
        check_sb();
        chk("start.pv_cnt", pv_cnt, 0);
        cyc(188);

        step("ccw1", 3'b100, 200, 1);
        chk("ccw1.pv_cnt", pv_cnt, 1);
        chk("ccw1.period", last_period, 199);
        step("ccw2", 3'b110, 200, 2);
        chk("ccw2.pv_cnt", pv_cnt, 2);
        chk("ccw2.period", last_period, 200);

        dir = 1'b1;
        push_exp("cw", 3'b110, 1'b1, 2, 1'b0, 1'b1);
        cyc(2);
        check_sb();
        dir = 1'b0;
        en = 1'b0;
        push_exp("en_off", 3'b110, 1'b0, 2, 1'b0, 1'b0);
        cyc(2);
        check_sb();
        en = 1'b1;

        step("to010", 3'b010, 30, 3);
        hall = 3'b000;
        cyc(5);
        hall = 3'b010;
        push_exp("glitch", 3'b010, 1'b0, 3, 1'b0, 1'b1);
        cyc(30);
        chk("glitch.hall_filt", int'(hall_filt), 2);
        check_sb();

        step("dn1", 3'b110, 30, 2);
        step("dn2", 3'b100, 30, 1);
        step("dn3", 3'b101, 30, 0);
        se0 = se_cnt;
        hall = 3'b010;
        push_exp("jump", 3'b010, 1'b0, 0, 1'b1, 1'b1);
        cyc(30);
        check_sb();
        chk("jump.step_err_pulses", se_cnt - se0, 1);

        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        push_exp("clr", 3'b010, 1'b0, 0, 1'b0, 1'b1);
        cyc(3);
        check_sb();

        se0 = se_cnt;
        hall = 3'b111;
        push_exp("inv", 3'b111, 1'b0, 0, 1'b1, 1'b1);
        cyc(20);
        check_sb();
        chk("inv.no_step_err", se_cnt - se0, 0);
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        cyc(2);
        chk("inv_clr.fault", int'(fault), 1);
        hall = 3'b010;
        cyc(30);
        fault_clr = 1'b1;
        cyc(1);
        fault_clr = 1'b0;
        cyc(3);
        chk("recover.fault", int'(fault), 0);

        rst = 1'b1;
        cyc(1);
        chk("midrst.position", int'(position), 0);
        chk("midrst.period", int'(period), (1 << PRW) - 1);
        chk("midrst.hall_filt", int'(hall_filt), 0);
        chk("midrst.u", int'(u), 0);
        rst = 1'b0;
        push_exp("rerun", 3'b010, 1'b0, 0, 1'b0, 1'b1);
        cyc(30);
        check_sb();

        for (int i = 0; i < 8; i++)
            step($sformatf("down%0d", i + 1), down_seq[i], 30, -(i + 1));
        step("wrap", 3'b101, 30, 7);

        pv0 = pv_cnt;
        cyc(1100);
        step("stall", 3'b001, 30, 6);
        chk("stall.pv", pv_cnt - pv0, 1);
        chk("stall.period", last_period, (1 << PRW) - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hall_commutator.md
# hall_commutator

Parametrised, registered successor to the combinational hall-to-phase decoder in the BLDC motor path. Synchronises and deglitches the 3-bit hall input, drives high-phase (`u`) and high-impedance (`z`) selects with a direction input, and tracks commutation steps as signed position and step period. Illegal hall codes or illegal step jumps latch a fault that floats all phases until it is cleared. Sits between the hall pins and the per-phase gate-drive/PWM logic, one instance per motor.

## Interface
- `FILTER_CYCLES`, 8: consecutive stable cycles required before a hall code is accepted (≥1).
- `POS_W`, 16: width of the signed position counter.
- `PERIOD_W`, 20: width of the step period counter.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `hall` in 3: raw hall inputs, `hall[2]`=H1 … `hall[0]`=H3, asynchronous.
- `en` in 1: 1 = drive phases; 0 = all phases high-Z (tracking continues).
- `dir` in 1: 0 = CCW (sequence 1→6), 1 = CW.
- `fault_clr` in 1: single-cycle request to clear a latched fault.
- `u` out 3: phase driven high, one-hot A=100, B=010, C=001, or 000.
- `z` out 3: phases in high-Z.
- `hall_filt` out 3: accepted (filtered) hall code.
- `position` out POS_W: signed step count, +1 per CCW step.
- `period` out PERIOD_W: clk cycles between the last two valid steps.
- `period_valid` out 1: one-cycle pulse when `period` updates.
- `step_err` out 1: one-cycle pulse on an illegal transition.
- `fault` out 1: sticky fault flag.

## Operation
- Hall sequence, index 1..6: 101, 100, 110, 010, 011, 001. Codes 000 and 111 are invalid.
- CCW table (index: u/z): 1: A/C, 2: A/B, 3: B/A, 4: B/C, 5: C/B, 6: C/A. The low phase is the remaining phase.
- CW: `u` = the CCW low phase; `z` is unchanged.
- Outputs are forced to `u`=000, `z`=111 when the state is not RUN, when `en`=0, or when the code is invalid.
- Filter: 2-flop synchroniser, then a stability counter.
  - The counter reloads whenever the synchronised value changes.
  - When the synchronised value differs from `hall_filt` and has been stable for `FILTER_CYCLES` cycles, it is loaded into `hall_filt`.
- FSM states:
  - INIT: entered on reset. Invalid codes are ignored. Moves to RUN on the first valid `hall_filt`. No step is counted; the period counter restarts at 0.
  - RUN: each `hall_filt` change is classified by index delta, modulo 6.
    - +1: `position`+1.
    - −1: `position`−1.
    - Any other delta: `step_err` pulse, go to FAULT.
    - Change to an invalid code: go to FAULT, no pulse.
    - On each ±1 step: `period` ← period counter value, `period_valid` pulse, counter restarts at 1.
  - FAULT: `fault`=1, outputs floated, `position` frozen. On `fault_clr` with a valid `hall_filt`, goes to INIT.
- `position` wraps in two's complement.
- The period counter saturates at all-ones; `period` = all-ones means the motor has stalled.
- A `fault_clr` arriving in the same cycle as a new fault event is ignored; the FSM stays in FAULT.

## Timing
- Reset values:
  - `u`=000, `z`=111, `hall_filt`=000.
  - `position`=0, `period`=all-ones, `period_valid`=0, `step_err`=0, `fault`=0.
  - FSM = INIT, filter counter = 0.
- Edge numbering: E0 is the first edge sampling a new stable `hall`.
  - `hall_filt` updates at E(FILTER_CYCLES+2).
  - `u`, `z`, `position`, `period`, `period_valid`, `step_err` and `fault` update one edge later.
  - Total latency is `FILTER_CYCLES`+3 cycles.
- A glitch shorter than `FILTER_CYCLES` cycles after synchronisation never reaches `hall_filt`.
- `en` and `dir` are registered: one-cycle effect on `u`/`z`.
- `rst` mid-operation returns every register to its reset value on the next edge.

## Structure
- Shared package (`hall_pkg`) holds:
  - hall code constants STATE1..STATE6, STATE_FAULT, STATE_NO_CONN;
  - phase constants A, B, C, ALL_ON, ALL_OFF;
  - a code-to-index function returning 0 for invalid codes;
  - a commutation function (index, dir → u, z).
- Sub-module `hall_glitch_filter` contains the synchroniser plus stability counter and outputs `hall_filt`. The FSM, tracking and output registers stay in `hall_commutator`.

## Test plan
- Reset, then hold 101 with `en`=1, `dir`=0, FILTER_CYCLES=8 → INIT to RUN; `u`=100, `z`=001 at edge 11; `position`=0; no `period_valid`.
- Step 101→100→110, 200 cycles per step → `position`=2; `period`=200 with one `period_valid` pulse per step. Repeat with `dir`=1 at 110 → `u`=001, `z`=100.
- Inject a 5-cycle 000 glitch on a stable 010 → `hall_filt` stays 010; no fault.
- Jump 101→010 → `step_err` pulse, `fault`=1, `u`=000, `z`=111. Then `fault_clr` → INIT, then RUN; `position` unchanged.
- Hold 111 for 20 cycles while in RUN → `fault`=1. Assert `fault_clr` while 111 persists → `fault` stays 1.
- With `POS_W`=4, make 8 steps down from 0 → `position`=−8. One more down-step → wraps to +7. Hold a code for 2^PERIOD_W cycles, then step → `period` = all-ones.
